// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that time-shares one 4x4 unsigned multiplier
// among NUM_REQ requesters, returning product and requester ID.

module multiply_4by4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] product
);
    assign product = {4'd0, a} * {4'd0, b};
endmodule

module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [4*NUM_REQ-1:0]   req_a,
    input  logic [4*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [7:0]             rsp_product,
    output logic [ID_W-1:0]        rsp_id,
    output logic [15:0]            done_count
);
    typedef enum logic [1:0] {IDLE, MUL, RSP} state_t;

    state_t            state;
    state_t            next_state;
    logic [3:0]        op_a;
    logic [3:0]        op_b;
    logic [ID_W-1:0]   id_reg;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic [NUM_REQ-1:0] grant;
    logic [7:0]        mul_p;
    logic              window;
    logic              found;
    logic              accept;

    function automatic logic [ID_W-1:0] rr_index(
        input logic [ID_W-1:0] base,
        input int              k
    );
        int s;
        s = (int'(base) + k) % NUM_REQ;
        return ID_W'(s);
    endfunction

    multiply_4by4 u_mul (
        .a       (op_a),
        .b       (op_b),
        .product (mul_p)
    );

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        window   = rst_n && ((state == IDLE) || (state == RSP && rsp_ready));
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[rr_index(rr_ptr, k)]) begin
                found    = 1'b1;
                grant_id = rr_index(rr_ptr, k);
            end
        end
        accept = window && found;
        if (accept) grant[grant_id] = 1'b1;
    end

    assign req_ready = grant;
    assign rsp_valid = (state == RSP);

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (accept) next_state = MUL;
            MUL:  next_state = RSP;
            RSP: begin
                if (rsp_ready) next_state = accept ? MUL : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a        <= '0;
            op_b        <= '0;
            id_reg      <= '0;
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            rsp_product <= '0;
            rsp_id      <= '0;
            done_count  <= '0;
        end else begin
            if (accept) begin
                op_a   <= req_a[{grant_id, 2'b00} +: 4];
                op_b   <= req_b[{grant_id, 2'b00} +: 4];
                id_reg <= grant_id;
                rr_ptr <= grant_id;
            end
            if (state == MUL) begin
                rsp_product <= mul_p;
                rsp_id      <= id_reg;
            end
            if (state == RSP && rsp_ready) done_count <= done_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.

module tb_mul_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_product;
    logic [1:0]  rsp_id;
    logic [15:0] done_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mul_share_arbiter #(.NUM_REQ(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id),
        .done_count  (done_count)
    );

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[4*i +: 4] = a;
        req_b[4*i +: 4] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int model_grant(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 4'hF;
        #1;
        tests++; if (req_ready !== 4'h0) begin fails++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        tests++; if (rsp_product !== 8'd0) begin fails++; $display("FAIL reset_product: got %0d want 0", rsp_product); end
        tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
        tests++; if (done_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", done_count); end
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        set_req(0, 4'd2, 4'd5);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_mul_valid: got %b want 0", rsp_valid); end
        @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
        tests++; if (rsp_product !== 8'd10) begin fails++; $display("FAIL single_product: got %0d want 10", rsp_product); end
        tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL single_id: got %0d want 0", rsp_id); end
        @(negedge clk);
        #1;
        tests++; if (done_count !== 16'd1) begin fails++; $display("FAIL single_count: got %0d want 1", done_count); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_drop: got %b want 0", rsp_valid); end
    endtask

    task automatic test_all4();
        logic [3:0] want;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), 4'd3);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            #1;
            want = 4'b0001 << (n % 4);
            tests++; if (req_ready !== want) begin fails++; $display("FAIL all4_grant%0d: got %b want %b", n, req_ready, want); end
            if (n > 0) begin
                tests++; if (rsp_valid !== 1'b1 || rsp_product !== 8'(((n - 1) % 4 + 1) * 3) || rsp_id !== 2'((n - 1) % 4)) begin
                    fails++; $display("FAIL all4_rsp%0d: got v=%b p=%0d id=%0d want p=%0d id=%0d", n, rsp_valid, rsp_product, rsp_id, ((n - 1) % 4 + 1) * 3, (n - 1) % 4);
                end
            end
            @(negedge clk);
            #1;
            tests++; if (req_ready !== 4'h0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL all4_mul%0d: got ready=%b v=%b want 0000 0", n, req_ready, rsp_valid); end
            @(negedge clk);
        end
        #1;
        req_valid = '0;
        tests++; if (rsp_product !== 8'd6 || rsp_id !== 2'd1) begin fails++; $display("FAIL all4_last: got p=%0d id=%0d want 6 1", rsp_product, rsp_id); end
        @(negedge clk);
        #1;
        tests++; if (done_count !== 16'd6) begin fails++; $display("FAIL all4_count: got %0d want 6", done_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        set_req(0, 4'd6, 4'd8);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL bp_grant0: got %b want 0001", req_ready); end
        @(negedge clk);
        set_req(1, 4'd3, 4'd4);
        req_valid = 4'b0010;
        #1;
        tests++; if (req_ready !== 4'h0) begin fails++; $display("FAIL bp_mul_ready: got %b want 0000", req_ready); end
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            tests++; if (rsp_valid !== 1'b1 || rsp_product !== 8'd48 || req_ready !== 4'h0) begin
                fails++; $display("FAIL bp_hold%0d: got v=%b p=%0d ready=%b want 1 48 0000", c, rsp_valid, rsp_product, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL bp_b2b_grant: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        tests++; if (rsp_valid !== 1'b0 || done_count !== 16'd1) begin fails++; $display("FAIL bp_after: got v=%b cnt=%0d want 0 1", rsp_valid, done_count); end
        @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_product !== 8'd12 || rsp_id !== 2'd1) begin
            fails++; $display("FAIL bp_req1: got v=%b p=%0d id=%0d want 1 12 1", rsp_valid, rsp_product, rsp_id);
        end
        @(negedge clk);
    endtask

    task automatic test_corner();
        logic [3:0] ta [3];
        logic [3:0] tb [3];
        int         te [3];
        ta = '{4'd15, 4'd0, 4'd4};
        tb = '{4'd15, 4'd9, 4'd2};
        te = '{225, 0, 8};
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_req(3, ta[i], tb[i]);
            req_valid = 4'b1000;
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            #1;
            tests++; if (rsp_valid !== 1'b1 || rsp_product !== 8'(te[i]) || rsp_id !== 2'd3) begin
                fails++; $display("FAIL corner%0d: got v=%b p=%0d id=%0d want 1 %0d 3", i, rsp_valid, rsp_product, rsp_id, te[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_req(0, 4'd3, 4'd3);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b0100;
        rst_n = 1'b0;
        #1;
        tests++; if (rsp_valid !== 1'b0 || rsp_product !== 8'd0 || rsp_id !== 2'd0) begin
            fails++; $display("FAIL mid_outputs: got v=%b p=%0d id=%0d want 0 0 0", rsp_valid, rsp_product, rsp_id);
        end
        tests++; if (done_count !== 16'd0) begin fails++; $display("FAIL mid_count: got %0d want 0", done_count); end
        tests++; if (req_ready !== 4'h0) begin fails++; $display("FAIL mid_ready: got %b want 0000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_no_rsp%0d: got %b want 0", c, rsp_valid); end
        end
        set_req(2, 4'd7, 4'd7);
        req_valid = 4'b0100;
        #1;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL mid_grant2: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        tests++; if (rsp_valid !== 1'b1 || rsp_product !== 8'd49 || rsp_id !== 2'd2) begin
            fails++; $display("FAIL mid_new: got v=%b p=%0d id=%0d want 1 49 2", rsp_valid, rsp_product, rsp_id);
        end
        @(negedge clk);
        #1;
        tests++; if (done_count !== 16'd1) begin fails++; $display("FAIL mid_new_count: got %0d want 1", done_count); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.done_count = 16'hFFFF;
        #1;
        release dut.done_count;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_req(1, 4'd1, 4'd1);
            req_valid = 4'b0010;
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            @(negedge clk);
            #1;
            tests++; if (done_count !== 16'(i)) begin fails++; $display("FAIL wrap%0d: got %0d want %0d", i, done_count, i); end
        end
    endtask

    task automatic test_random();
        logic [3:0] mv;
        logic [3:0] ma [4];
        logic [3:0] mb [4];
        logic [3:0] want;
        int  last, g, p_id, p_prod, r_id, r_prod, cnt;
        bit  mul_busy, rsp_out, win;
        do_reset();
        mv = '0;
        last = 3;
        cnt = 0;
        mul_busy = 1'b0;
        rsp_out = 1'b0;
        p_id = 0; p_prod = 0; r_id = 0; r_prod = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!mv[i] && $urandom_range(2) == 0) begin
                    mv[i] = 1'b1;
                    ma[i] = 4'($urandom);
                    mb[i] = 4'($urandom);
                    set_req(i, ma[i], mb[i]);
                end
            end
            req_valid = mv;
            rsp_ready = ($urandom_range(3) != 0);
            #1;
            win = (!mul_busy && !rsp_out) || (rsp_out && rsp_ready);
            g = win ? model_grant(mv, last) : -1;
            want = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            tests++; if (req_ready !== want) begin fails++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, req_ready, want); end
            tests++; if (rsp_valid !== rsp_out) begin fails++; $display("FAIL rand_valid@%0d: got %b want %b", cyc, rsp_valid, rsp_out); end
            if (rsp_out) begin
                tests++; if (rsp_product !== 8'(r_prod) || rsp_id !== 2'(r_id)) begin
                    fails++; $display("FAIL rand_rsp@%0d: got p=%0d id=%0d want %0d %0d", cyc, rsp_product, rsp_id, r_prod, r_id);
                end
            end
            tests++; if (done_count !== 16'(cnt)) begin fails++; $display("FAIL rand_count@%0d: got %0d want %0d", cyc, done_count, cnt); end
            @(posedge clk);
            if (rsp_out && rsp_ready) begin
                cnt++;
                rsp_out = 1'b0;
            end
            if (mul_busy) begin
                mul_busy = 1'b0;
                rsp_out = 1'b1;
                r_id = p_id;
                r_prod = p_prod;
            end
            if (g >= 0) begin
                mul_busy = 1'b1;
                p_id = g;
                p_prod = int'(ma[g]) * int'(mb[g]);
                last = g;
                mv[g] = 1'b0;
            end
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_all4();
        test_backpressure();
        test_corner();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter and sequencer that time-shares one `multiply_4by4` unsigned 4x4 multiplier among NUM_REQ requesters. Each requester offers an operand pair over a valid/ready handshake. The block registers the granted operands, drives the shared multiplier, and registers the product. It returns the product with the requester ID over a valid/ready response channel and counts completed operations.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ), width of requester ID

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  4*NUM_REQ  operand A, requester i at bits [4i+3:4i]
- req_b  in  4*NUM_REQ  operand B, same packing
- req_ready  out  NUM_REQ  one-hot grant/accept; at most one bit high
- rsp_valid  out  1  product valid
- rsp_ready  in  1  consumer accepts product
- rsp_product  out  8  A*B, unsigned
- rsp_id  out  ID_W  index of the requester that issued the product
- done_count  out  16  completed responses, wraps 0xFFFF->0x0000

## Operation
- FSM states: IDLE, MUL, RSP. Reset state is IDLE.
- Reset values: req_ready=0, rsp_valid=0, rsp_product=0, rsp_id=0, done_count=0, operand regs=0, rr_ptr=NUM_REQ-1.
- Grant window: open in IDLE, or in RSP when rsp_ready=1 (back-to-back).
- Grant rule: requester i is granted if the window is open and req_valid[i]=1. Priority is round-robin starting at (rr_ptr+1) mod NUM_REQ. Only the granted bit of req_ready is high. req_ready is combinational from req_valid, state, rr_ptr and rsp_ready.
- Accept (req_valid[i]&req_ready[i] at an edge):
  - latch req_a/req_b slice i into the operand regs;
  - latch i into id_reg;
  - set rr_ptr=i;
  - go to MUL.
- MUL: the shared multiplier is driven from the operand regs. At the next edge:
  - product reg <= multiplier output;
  - rsp_id <= id_reg;
  - rsp_valid <= 1;
  - go to RSP.
- RSP: rsp_valid=1. rsp_product and rsp_id stay stable until rsp_valid&rsp_ready at an edge.
  - On that edge, done_count increments.
  - If a new accept also occurs on that edge, go to MUL and drop rsp_valid to 0.
  - Otherwise go to IDLE and drop rsp_valid to 0.
- rsp_product holds its last value after the response is consumed. It is not cleared.
- Requesters must hold req_valid, req_a and req_b stable until accepted. The block samples operands only on the accepting edge.
- Width rule: the product is always 8 bits. Maximum is 15*15=225, so there is no overflow.
- Reset asserted mid-operation (MUL or RSP): everything returns immediately to reset values. The in-flight request is dropped without a response, and done_count is cleared.

## Timing
- Latency: request accepted at edge E0; rsp_valid=1 in the cycle after edge E1 (one cycle after E0).
- Throughput: one operation per 2 cycles with rsp_ready held high and requests pending. Zero-wait back-to-back accepts happen from RSP.
- req_ready is never high in MUL.
- rsp_valid is never high in IDLE or MUL.
- rr_ptr changes only on an accept.
- A requester whose req_valid stays high is granted within NUM_REQ accepts.
- done_count updates on the response handshake edge, one count per response.

## Test plan
- Single request, req 0 A=2 B=5, rsp_ready=1:
  - req_ready[0]=1 in the same cycle;
  - after the accept edge plus one edge, rsp_valid=1, rsp_product=10, rsp_id=0;
  - done_count=1 after the handshake.
- All 4 requesters valid continuously (A=i+1, B=3), rsp_ready=1:
  - grant order 0,1,2,3,0,1;
  - products 3,6,9,12,3,6;
  - one accept every 2 cycles.
- Backpressure, A=6 B=8, rsp_ready=0 for 5 cycles after rsp_valid rises, with req 1 valid:
  - rsp_product=48 held stable;
  - req_ready all 0 while rsp_ready=0;
  - req 1 is accepted on the same edge as the response handshake.
- Corner operands:
  - 15*15 -> 225;
  - 0*9 -> 0;
  - 4*2 -> 8.
- Reset mid-operation: assert rst_n=0 in MUL.
  - All outputs return to reset values immediately;
  - after release, a new request req 2 (A=7, B=7) yields 49 with rsp_id=2;
  - the earlier request produces no response.
- Counter wrap: preload via 65535 completed responses (or force done_count=0xFFFF), then one more response -> done_count=0.
